prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Write side of the tiny-CPU program store: takes a byte stream from the pins, fills a
//  DEPTH x DATA_W program RAM, verifies a trailing checksum and releases the CPU.
//  CPU fetch port (fetch_addr = pc, fetch_instr = instruction) replaces the fixed ROM.
//  cpu_hold drives the CPU run/load select: hold while loading or after a bad program.
// PARAMETERS
//  ADDR_W    4   fetch/write address width
//  DATA_W    8   instruction width
//  DEPTH     16  RAM words (= 2**ADDR_W)
//  PROG_LEN  6   program bytes per session, 1..DEPTH (CPU pc wraps after addr 5)
// PORTS
//  clk          in   1         clock, all state on rising edge
//  rst          in   1         synchronous reset, active-high
//  load_start   in   1         1-cycle pulse: begin (or restart) a load session
//  in_valid     in   1         in_data valid
//  in_data      in   DATA_W    program / checksum byte
//  in_ready     out  1         byte accepted when in_valid && in_ready
//  fetch_addr   in   ADDR_W    CPU program counter
//  fetch_instr  out  DATA_W    mem[fetch_addr], combinational
//  load_busy    out  1         session in progress (LOAD or CSUM)
//  load_done    out  1         session finished, sticky until next load_start
//  csum_ok      out  1         checksum matched; valid while load_done=1
//  cpu_hold     out  1         1 = CPU held (load mode), 0 = CPU runs
//  words_loaded out  ADDR_W+1  program bytes written this session
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, wr_addr=0, sum=0, words_loaded=0, all RAM words=0;
//   outputs in_ready=0, load_busy=0, load_done=0, csum_ok=0, cpu_hold=1.
//  FSM IDLE -> LOAD -> CSUM -> DONE; DONE -> LOAD on load_start.
//  IDLE: in_ready=0, bytes ignored; load_start -> LOAD next cycle, wr_addr=0, sum=0.
//  LOAD: in_ready=1; on handshake mem[wr_addr]<=in_data, wr_addr++, words_loaded++,
//   sum<=sum+in_data (mod 2**DATA_W). Handshake of byte #PROG_LEN -> CSUM next cycle.
//  CSUM: in_ready=1; on handshake csum_ok<=((sum+in_data) mod 2**DATA_W)==0,
//   load_done<=1, -> DONE. Checksum byte is not written to RAM.
//  DONE: in_ready=0; cpu_hold = ~csum_ok; load_done=1 until load_start.
//  load_busy=1 in LOAD and CSUM; cpu_hold=1 in IDLE, LOAD, CSUM.
//  load_start in LOAD/CSUM: restart (wr_addr=0, sum=0, words_loaded=0, -> LOAD); a
//   handshake in the same cycle is dropped (load_start wins); RAM keeps old contents.
//  load_start in DONE: load_done<=0, csum_ok<=0, cpu_hold=1 from next cycle.
//  No handshake while in_valid=0; in_valid may drop any cycle; no data is lost or duplicated.
//  Latency: byte written 1 cycle after handshake; load_done/csum_ok/cpu_hold change
//   1 cycle after checksum handshake.
//  Fetch: async read; same-cycle write to fetch_addr returns old data, new data next cycle.
//   Addresses >= PROG_LEN return stored value (0 after reset). No wrap of wr_addr needed:
//   LOAD never exceeds PROG_LEN writes.
//  rst mid-session: immediate return to reset state, partial program discarded (RAM cleared).
// TESTING
//  1 Reset: rst 2 cycles -> in_ready=0, cpu_hold=1, load_done=0, fetch_instr=8'h00 for addr 0..15.
//  2 Good load: start, bytes 15,23,31,42,51,60 then A4 -> load_done=1, csum_ok=1, cpu_hold=0,
//    words_loaded=6, fetch_addr=3 -> 8'h42, fetch_addr=6 -> 8'h00.
//  3 Bad checksum: same 6 bytes then A5 -> load_done=1, csum_ok=0, cpu_hold=1, RAM holds bytes.
//  4 Gapped valid: in_valid toggling 1/0 randomly -> exactly 6 writes, words_loaded steps by 1
//    per handshake only, result as test 2.
//  5 Restart: start, 3 bytes AA,BB,CC, start, test-2 stream -> addr0=8'h15, csum_ok=1;
//    handshake coincident with restart start pulse not written.
//  6 Reset mid-load after 4 bytes -> IDLE, cpu_hold=1, all fetches 8'h00, words_loaded=0.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream load port plus CPU fetch port of the program store.
interface prog_loader_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              load_start;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic [ADDR_W-1:0] fetch_addr;
   logic [DATA_W-1:0] fetch_instr;

   // Pin/CPU side: drives the stream and the program counter.
   modport master (
      output load_start, in_valid, in_data, fetch_addr,
      input  in_ready, fetch_instr
   );

   // Loader side: accepts the stream and serves instruction fetches.
   modport slave (
      input  load_start, in_valid, in_data, fetch_addr,
      output in_ready, fetch_instr
   );
endinterface

// File: rtl/prog_loader.sv
// Program store write side: fills the program RAM from a byte stream, checks a
// trailing additive checksum and holds the CPU until a valid program is present.
module prog_loader #(
   parameter int ADDR_W   = 4,
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int PROG_LEN = 6
) (
   input  logic              clk,
   input  logic              rst,
   prog_loader_if.slave      bus,
   output logic              load_busy,
   output logic              load_done,
   output logic              csum_ok,
   output logic              cpu_hold,
   output logic [ADDR_W:0]   words_loaded
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CSUM = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Count value at which the next accepted byte is the last program byte.
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(PROG_LEN - 1);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              ready;
   logic              hs;
   logic              wr_en;
   logic              csum_en;

   // Checksum accumulation wraps modulo 2**DATA_W.
   function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
      return a + b;
   endfunction

   // A restart pulse takes priority over any byte offered in the same cycle.
   assign hs      = bus.in_valid && ready && !bus.load_start;
   assign wr_en   = hs && (state == S_LOAD);
   assign csum_en = hs && (state == S_CSUM);

   assign bus.in_ready    = ready;
   assign bus.fetch_instr = mem[bus.fetch_addr];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and per-state handshake/status outputs.
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      load_busy = 1'b0;
      cpu_hold  = 1'b1;
      case (state)
         S_IDLE: begin
            if (bus.load_start) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            ready     = 1'b1;
            load_busy = 1'b1;
            if (bus.load_start) begin
               state_nxt = S_LOAD;
            end else if (wr_en && (words_loaded == LAST_IDX)) begin
               state_nxt = S_CSUM;
            end
         end
         S_CSUM: begin
            ready     = 1'b1;
            load_busy = 1'b1;
            if (bus.load_start) begin
               state_nxt = S_LOAD;
            end else if (csum_en) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            cpu_hold = ~csum_ok;
            if (bus.load_start) state_nxt = S_LOAD;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Session bookkeeping: write pointer, running sum, byte count and result flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_addr      <= '0;
         sum          <= '0;
         words_loaded <= '0;
         load_done    <= 1'b0;
         csum_ok      <= 1'b0;
      end else if (bus.load_start) begin
         wr_addr      <= '0;
         sum          <= '0;
         words_loaded <= '0;
         load_done    <= 1'b0;
         csum_ok      <= 1'b0;
      end else if (wr_en) begin
         wr_addr      <= wr_addr + 1'b1;
         sum          <= csum_add(sum, bus.in_data);
         words_loaded <= words_loaded + 1'b1;
      end else if (csum_en) begin
         csum_ok      <= (csum_add(sum, bus.in_data) == '0);
         load_done    <= 1'b1;
      end
   end

   // Program RAM: cleared by reset so a discarded session leaves no stale code.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= bus.in_data;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader against a session-level reference model.
module tb_prog_loader;
   localparam int ADDR_W   = 4;
   localparam int DATA_W   = 8;
   localparam int DEPTH    = 16;
   localparam int PROG_LEN = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   logic              load_busy;
   logic              load_done;
   logic              csum_ok;
   logic              cpu_hold;
   logic [ADDR_W:0]   words_loaded;

   prog_loader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .PROG_LEN(PROG_LEN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .load_busy(load_busy),
      .load_done(load_done),
      .csum_ok(csum_ok),
      .cpu_hold(cpu_hold),
      .words_loaded(words_loaded)
   );

   // Reference model: what the program store should hold and report.
   logic [7:0] m_mem [DEPTH];
   bit         m_active;
   bit         m_done;
   bit         m_ok;
   int         m_cnt;
   logic [7:0] m_sum;

   int n_total = 0;
   int n_bad   = 0;

   logic [7:0] good_prog [PROG_LEN];
   logic [7:0] rnd_prog  [PROG_LEN];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive, check combinational outputs, advance model, check state.
   task automatic step(input bit r, input bit st, input bit v, input logic [7:0] d, input int fa);
      @(negedge clk);
      rst            = r;
      bus.load_start = st;
      bus.in_valid   = v;
      bus.in_data    = d;
      bus.fetch_addr = ADDR_W'(fa);
      #1;
      if (!r) begin
         chk("ready", 32'(bus.in_ready), 32'(m_active));
         chk("fetch_pre", 32'(bus.fetch_instr), 32'(m_mem[fa]));
      end
      @(posedge clk);
      if (r) begin
         foreach (m_mem[i]) m_mem[i] = 8'h00;
         m_active = 0; m_done = 0; m_ok = 0; m_cnt = 0; m_sum = 8'h00;
      end else if (st) begin
         m_active = 1; m_done = 0; m_ok = 0; m_cnt = 0; m_sum = 8'h00;
      end else if (m_active && v) begin
         if (m_cnt < PROG_LEN) begin
            m_mem[m_cnt] = d;
            m_sum        = m_sum + d;
            m_cnt++;
         end else begin
            m_ok     = (8'(m_sum + d) == 8'h00);
            m_done   = 1;
            m_active = 0;
         end
      end
      #1;
      chk("busy", 32'(load_busy), 32'(m_active));
      chk("done", 32'(load_done), 32'(m_done));
      chk("csum_ok", 32'(csum_ok), 32'(m_ok));
      chk("hold", 32'(cpu_hold), 32'(!(m_done && m_ok)));
      chk("words", 32'(words_loaded), 32'(m_cnt));
      chk("fetch_post", 32'(bus.fetch_instr), 32'(m_mem[fa]));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 8'($urandom), int'($urandom_range(0, DEPTH-1)));
   endtask

   // Offer one byte, optionally preceded by a random number of invalid cycles.
   task automatic send(input logic [7:0] d, input int maxgap);
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      idle(gap);
      step(0, 0, 1, d, int'($urandom_range(0, DEPTH-1)));
   endtask

   task automatic load_good(input logic [7:0] csum, input int maxgap);
      step(0, 1, 0, 8'h00, 0);
      for (int i = 0; i < PROG_LEN; i++) send(good_prog[i], maxgap);
      send(csum, maxgap);
   endtask

   initial begin
      good_prog = '{8'h15, 8'h23, 8'h31, 8'h42, 8'h51, 8'h60};
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      m_active = 0; m_done = 0; m_ok = 0; m_cnt = 0; m_sum = 8'h00;
      rst = 1'b1;
      bus.load_start = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_data    = 8'h00;
      bus.fetch_addr = '0;

      // Reset and cleared RAM
      step(1, 0, 0, 8'h00, 0);
      step(1, 0, 0, 8'h00, 0);
      chk("rst_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_hold", 32'(cpu_hold), 32'd1);
      for (int a = 0; a < DEPTH; a++) begin
         step(0, 0, 1, 8'hFF, a);
         chk("rst_mem", 32'(bus.fetch_instr), 32'd0);
      end

      // Good load
      load_good(8'hA4, 0);
      step(0, 0, 0, 8'h00, 3);
      chk("good_done", 32'(load_done), 32'd1);
      chk("good_ok", 32'(csum_ok), 32'd1);
      chk("good_hold", 32'(cpu_hold), 32'd0);
      chk("good_words", 32'(words_loaded), 32'd6);
      chk("good_a3", 32'(bus.fetch_instr), 32'h42);
      step(0, 0, 1, 8'h77, 6);
      chk("good_a6", 32'(bus.fetch_instr), 32'h00);

      // Bad checksum
      load_good(8'hA5, 0);
      step(0, 0, 0, 8'h00, 5);
      chk("bad_done", 32'(load_done), 32'd1);
      chk("bad_ok", 32'(csum_ok), 32'd0);
      chk("bad_hold", 32'(cpu_hold), 32'd1);
      chk("bad_a5", 32'(bus.fetch_instr), 32'h60);

      // Gapped valid
      load_good(8'hA4, 3);
      step(0, 0, 0, 8'h00, 0);
      chk("gap_ok", 32'(csum_ok), 32'd1);
      chk("gap_words", 32'(words_loaded), 32'd6);
      chk("gap_a0", 32'(bus.fetch_instr), 32'h15);

      // Restart mid-session; byte offered with the restart pulse is dropped
      step(0, 1, 0, 8'h00, 0);
      send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0);
      step(0, 1, 1, 8'hEE, 3);
      chk("rs_words", 32'(words_loaded), 32'd0);
      chk("rs_a3", 32'(bus.fetch_instr), 32'h42);
      for (int i = 0; i < PROG_LEN; i++) send(good_prog[i], 1);
      send(8'hA4, 1);
      step(0, 0, 0, 8'h00, 0);
      chk("rs_a0", 32'(bus.fetch_instr), 32'h15);
      chk("rs_ok", 32'(csum_ok), 32'd1);

      // Reset mid-load after 4 bytes
      step(0, 1, 0, 8'h00, 0);
      for (int i = 0; i < 4; i++) send(good_prog[i], 0);
      step(1, 0, 0, 8'h00, 0);
      chk("mr_hold", 32'(cpu_hold), 32'd1);
      chk("mr_words", 32'(words_loaded), 32'd0);
      chk("mr_busy", 32'(load_busy), 32'd0);
      for (int a = 0; a < DEPTH; a++) begin
         step(0, 0, 0, 8'h00, a);
         chk("mr_mem", 32'(bus.fetch_instr), 32'd0);
      end

      // Random sessions: random bytes, gaps, checksum right or wrong, stray restarts
      for (int s = 0; s < 12; s++) begin
         logic [7:0] acc;
         logic [7:0] cs;
         acc = 8'h00;
         step(0, 1, 0, 8'h00, 0);
         for (int i = 0; i < PROG_LEN; i++) begin
            rnd_prog[i] = 8'($urandom);
            acc = acc + rnd_prog[i];
            if ($urandom_range(0, 19) == 0) step(0, 1, $urandom_range(0, 1) == 1, 8'($urandom), 0);
            send(rnd_prog[i], 2);
         end
         cs = ($urandom_range(0, 1) == 1) ? 8'(8'h00 - acc) : 8'($urandom);
         send(cs, 2);
         idle(int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
